// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the memory/I/O bus arbiter: bus widths, the
// active-low handshake and read/write constants, and the arbiter states.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  localparam int BUS_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH     = 8;

  // Active-low handshake levels
  localparam logic Enable_  = 1'b0;
  localparam logic Disable_ = 1'b1;

  // Shared bus direction (active-low write)
  localparam logic Read  = 1'b1;
  localparam logic Write = 1'b0;

  // Arbiter states
  typedef enum logic [2:0] {
    ArbIdle    = 3'd0,
    ArbDrain   = 3'd1,
    ArbGrant   = 3'd2,
    ArbRelease = 3'd3,
    ArbRevoke  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Responder side of the DMA breq_/bgrt_ handshake. The CPU owns the shared bus
// by default; on a DMA request the CPU is stalled at a cycle boundary, the bus
// is granted to the DMA master, and it is returned on release or after
// MAX_HOLD grant cycles (hold-timeout, which also sets the sticky err flag).
//
// Ports:
//   clk, reset_            clock, synchronous active-low reset
//   breq_ / bgrt_          DMA request in / grant out (active-low, registered)
//   cpu_busy / cpu_hold    CPU mid-cycle in / CPU stall out (registered)
//   cpu_*, dma_*           master address, write data, read/write
//   mem_addr/odata/rw_     shared bus, muxed from the current state
//   err_clr / err          clear / sticky hold-timeout flag
//   gcnt                   grants issued, wraps at 256
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 64,   // 2..255
  parameter int MIN_CPU  = 2     // 0..255
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic                      breq_,
  output logic                      bgrt_,
  input  logic                      cpu_busy,
  output logic                      cpu_hold,
  input  logic [BUS_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [BUS_ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0]     cpu_odata,
  input  logic [DATA_WIDTH-1:0]     dma_odata,
  input  logic                      cpu_rw_,
  input  logic                      dma_rw_,
  output logic [BUS_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_odata,
  output logic                      mem_rw_,
  input  logic                      err_clr,
  output logic                      err,
  output logic [7:0]                gcnt
);

  // Hold counter starts at 0 on the first grant cycle, so the last allowed
  // grant cycle is the one where it reads MAX_HOLD-1.
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [7:0] FAIR_LOAD = 8'(MIN_CPU);

  arb_state_e r_state;
  logic       r_bgrt_;
  logic       r_cpu_hold;
  logic       r_err;
  logic [7:0] r_gcnt;
  logic [7:0] r_hold;
  logic [7:0] r_fair;

  arb_state_e w_next_state;
  logic       w_grant_start;
  logic       w_timeout;

  // Next-state decode and the one-cycle grant/timeout strobes
  always_comb begin
    w_next_state  = r_state;
    w_grant_start = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      ArbIdle: begin
        if ((breq_ == Enable_) && (r_fair == 8'd0)) begin
          w_next_state = ArbDrain;
        end else begin
          w_next_state = ArbIdle;
        end
      end
      ArbDrain: begin
        // A withdrawn request wins over a finished CPU cycle: no grant.
        if (breq_ == Disable_) begin
          w_next_state = ArbIdle;
        end else if (!cpu_busy) begin
          w_next_state  = ArbGrant;
          w_grant_start = 1'b1;
        end else begin
          w_next_state = ArbDrain;
        end
      end
      ArbGrant: begin
        if (breq_ == Disable_) begin
          w_next_state = ArbRelease;
        end else if (r_hold == HOLD_LAST) begin
          w_next_state = ArbRevoke;
          w_timeout    = 1'b1;
        end else begin
          w_next_state = ArbGrant;
        end
      end
      ArbRelease: begin
        w_next_state = ArbIdle;
      end
      ArbRevoke: begin
        if (breq_ == Disable_) begin
          w_next_state = ArbRelease;
        end else begin
          w_next_state = ArbRevoke;
        end
      end
      default: begin
        w_next_state = ArbIdle;
      end
    endcase
  end

  // State, registered handshake outputs, counters and sticky error
  always_ff @(posedge clk) begin
    if (!reset_) begin
      r_state    <= ArbIdle;
      r_bgrt_    <= Disable_;
      r_cpu_hold <= 1'b0;
      r_err      <= 1'b0;
      r_gcnt     <= 8'd0;
      r_hold     <= 8'd0;
      r_fair     <= 8'd0;
    end else begin
      r_state    <= w_next_state;
      // Outputs are registered from the next state so they line up with it.
      r_bgrt_    <= (w_next_state == ArbGrant) ? Enable_ : Disable_;
      r_cpu_hold <= (w_next_state != ArbIdle);

      if (w_grant_start) begin
        r_gcnt <= r_gcnt + 8'd1;
      end else begin
        r_gcnt <= r_gcnt;
      end

      if (w_grant_start) begin
        r_hold <= 8'd0;
      end else if (r_state == ArbGrant) begin
        r_hold <= r_hold + 8'd1;
      end else begin
        r_hold <= r_hold;
      end

      if (r_state == ArbRelease) begin
        r_fair <= FAIR_LOAD;
      end else if ((r_state == ArbIdle) && (r_fair != 8'd0)) begin
        r_fair <= r_fair - 8'd1;
      end else begin
        r_fair <= r_fair;
      end

      // Timeout has priority over a simultaneous clear.
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Shared bus steering; the turnaround states park the bus in a safe read
  always_comb begin
    mem_addr  = cpu_addr;
    mem_odata = cpu_odata;
    mem_rw_   = cpu_rw_;
    case (r_state)
      ArbGrant: begin
        mem_addr  = dma_addr;
        mem_odata = dma_odata;
        mem_rw_   = dma_rw_;
      end
      ArbIdle, ArbDrain: begin
        mem_addr  = cpu_addr;
        mem_odata = cpu_odata;
        mem_rw_   = cpu_rw_;
      end
      ArbRelease, ArbRevoke: begin
        mem_addr  = {BUS_ADDR_WIDTH{1'b0}};
        mem_odata = {DATA_WIDTH{1'b0}};
        mem_rw_   = Read;
      end
      default: begin
        mem_addr  = {BUS_ADDR_WIDTH{1'b0}};
        mem_odata = {DATA_WIDTH{1'b0}};
        mem_rw_   = Read;
      end
    endcase
  end

  assign bgrt_    = r_bgrt_;
  assign cpu_hold = r_cpu_hold;
  assign err      = r_err;
  assign gcnt     = r_gcnt;

endmodule
